// File: rtl/text_renderer_pkg.sv
// Shared definitions for the text-mode renderer: fetch FSM states,
// default screen geometry and the VRAM cell word layout.
package text_renderer_pkg;
  localparam int COLS_DEFAULT = 40;
  localparam int ROWS_DEFAULT = 25;
  localparam int CHAR_H       = 8;
  localparam int PIX_PER_LINE = 320;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TEXT, S_FONT, S_READY} fetch_state_t;

  typedef struct packed {
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] chr;
  } cell_t;
endpackage

// File: rtl/text_renderer_shifter.sv
// Per-cell pixel shifter: takes a glyph row plus colours on load, emits one
// registered palette index per shift, optionally with fg/bg swapped.
module text_renderer_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_glyph,
  input  logic [3:0] i_fg,
  input  logic [3:0] i_bg,
  input  logic       i_swap,
  output logic [3:0] o_color,
  output logic       o_valid
);
  logic [7:0] r_sh;
  logic [3:0] r_fg, r_bg, r_color;
  logic       r_swap, r_valid;
  logic       w_bit, w_sw;
  logic [3:0] w_fg, w_bg, w_color;

  // A load cycle is also a pixel cycle, so it renders straight from the inputs.
  assign w_bit   = i_load ? i_glyph[7] : r_sh[7];
  assign w_fg    = i_load ? i_fg : r_fg;
  assign w_bg    = i_load ? i_bg : r_bg;
  assign w_sw    = i_load ? i_swap : r_swap;
  assign w_color = (w_bit ^ w_sw) ? w_fg : w_bg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_fg    <= '0;
      r_bg    <= '0;
      r_swap  <= 1'b0;
      r_color <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh   <= {i_glyph[6:0], 1'b0};
        r_fg   <= i_fg;
        r_bg   <= i_bg;
        r_swap <= i_swap;
      end else if (i_shift) begin
        r_sh <= {r_sh[6:0], 1'b0};
      end
      r_valid <= i_shift;
      r_color <= i_shift ? w_color : 4'd0;
    end
  end

  assign o_color = r_color;
  assign o_valid = r_valid;
endmodule

// File: rtl/text_renderer.sv
// 40x25 text-mode pixel generator: walks the cell grid, fetches cell word and
// glyph row, shifts out palette indices. TEXT_RENDERER_CURSOR_EN adds a blinking cursor.
module text_renderer
  import text_renderer_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        active,
  output logic [9:0]  vram_addr,
  input  logic [15:0] vram_rddata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_rddata,
`ifdef TEXT_RENDERER_CURSOR_EN
  input  logic [4:0]  cursor_row,
  input  logic [5:0]  cursor_col,
`endif
  output logic [3:0]  pix_color,
  output logic        pix_valid
);
  localparam logic [5:0] COLS_W    = 6'(COLS);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0] ROWS_W    = 5'(ROWS);
  localparam logic [9:0] BASE_STEP = 10'(COLS);
  localparam logic [2:0] SCAN_LAST = 3'(CHAR_H - 1);

  fetch_state_t r_state;
  logic [4:0]  r_row;
  logic [2:0]  r_scan;
  logic [9:0]  r_base;
  logic [5:0]  r_col, r_cell;
  logic [2:0]  r_phase;
  logic        r_first, r_line_ok;
  logic [10:0] r_font_addr;
  logic [3:0]  r_fg_h, r_bg_h;
  logic        r_swap_h;
  logic [7:0]  r_glyph;

  cell_t       w_cell;
  logic        w_adv, w_go, w_shift, w_load, w_swap;
  logic [4:0]  w_row_nx;

  assign w_cell   = cell_t'(vram_rddata);
  assign w_adv    = !r_first && (r_scan == SCAN_LAST) && (r_row < ROWS_W);
  assign w_row_nx = r_row + {4'd0, w_adv};
  // frame_start together with line_start always starts row 0
  assign w_go     = line_start && (frame_start || (w_row_nx < ROWS_W));
  assign w_shift  = active && r_line_ok && (r_cell < COLS_W) && !frame_start;
  assign w_load   = w_shift && (r_phase == 3'd0);

`ifdef TEXT_RENDERER_CURSOR_EN
  logic [5:0] r_fcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_fcnt <= '0;
    else if (frame_start) r_fcnt <= r_fcnt + 6'd1;
  end
  assign w_swap = r_fcnt[5] && (r_row == cursor_row) && (r_col == cursor_col);
`else
  assign w_swap = 1'b0;
`endif

  // Row/scanline bookkeeping; line_base accumulates COLS per row advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_scan    <= '0;
      r_base    <= '0;
      r_first   <= 1'b1;
      r_line_ok <= 1'b0;
    end else if (frame_start) begin
      r_row     <= '0;
      r_scan    <= '0;
      r_base    <= '0;
      r_first   <= !line_start;
      r_line_ok <= line_start;
    end else if (line_start) begin
      r_first   <= 1'b0;
      r_line_ok <= w_go;
      if (!r_first) r_scan <= r_scan + 3'd1;
      if (w_adv) begin
        r_row  <= r_row + 5'd1;
        r_base <= r_base + BASE_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cell  <= '0;
      r_phase <= '0;
    end else if (frame_start || line_start) begin
      r_cell  <= '0;
      r_phase <= '0;
    end else if (w_shift) begin
      r_phase <= r_phase + 3'd1;
      if (r_phase == 3'd7) r_cell <= r_cell + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_font_addr <= '0;
      r_fg_h      <= '0;
      r_bg_h      <= '0;
      r_swap_h    <= 1'b0;
      r_glyph     <= '0;
    end else if (line_start) begin
      r_state <= w_go ? S_ADDR : S_IDLE;
      r_col   <= '0;
    end else if (frame_start) begin
      r_state <= S_IDLE;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_ADDR: r_state <= S_TEXT;
        S_TEXT: begin
          r_font_addr <= {w_cell.chr, r_scan};
          r_fg_h      <= w_cell.fg;
          r_bg_h      <= w_cell.bg;
          r_swap_h    <= w_swap;
          r_state     <= S_FONT;
        end
        S_FONT: begin
          r_glyph <= font_rddata;
          r_state <= S_READY;
        end
        S_READY: if (w_load) begin
          if (r_col == LAST_COL) begin
            r_state <= S_IDLE;
          end else begin
            r_col   <= r_col + 6'd1;
            r_state <= S_ADDR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vram_addr = r_base + {4'd0, r_col};
  // The font ROM sees the char code in the same cycle the cell word arrives.
  assign font_addr = (r_state == S_TEXT) ? {w_cell.chr, r_scan} : r_font_addr;

  text_renderer_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_glyph (r_glyph),
    .i_fg    (r_fg_h),
    .i_bg    (r_bg_h),
    .i_swap  (r_swap_h),
    .o_color (pix_color),
    .o_valid (pix_valid)
  );
endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: table-driven first-cell vectors plus random VRAM/font
// contents checked cycle by cycle against a line/pixel-index reference model.
module tb_text_renderer;
  import text_renderer_pkg::*;

`ifdef TEXT_RENDERER_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, frame_start, line_start, active;
  logic [9:0]  vram_addr;
  logic [15:0] vram_rddata;
  logic [10:0] font_addr;
  logic [7:0]  font_rddata;
  logic [3:0]  pix_color;
  logic        pix_valid;

  logic [15:0] vram [0:1023];
  logic [7:0]  font [0:2047];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_rddata <= vram[vram_addr];
    font_rddata <= font[font_addr];
  end

  text_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .active      (active),
    .vram_addr   (vram_addr),
    .vram_rddata (vram_rddata),
    .font_addr   (font_addr),
    .font_rddata (font_rddata),
`ifdef TEXT_RENDERER_CURSOR_EN
    .cursor_row  (5'd0),
    .cursor_col  (6'd1),
`endif
    .pix_color   (pix_color),
    .pix_valid   (pix_valid)
  );

  typedef struct {
    logic [15:0]       word;
    logic [7:0]        glyph;
    bit                same;   // frame_start and line_start in one cycle
    logic [10:0]       faddr;
    logic [0:7][3:0]   pix;
  } vec_t;

  int total = 0, bad = 0;
  int L = -1, k = 0, fcnt = 0;
  logic       exp_v = 1'b0;
  logic [3:0] exp_c = 4'd0;
  logic       obs_v;
  logic [3:0] obs_c;
  logic [9:0] obs_va;
  logic [10:0] obs_fa;
  bit  track = 0, seen999 = 0;
  int  last_va = 0, cnt_v = 0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // One clock: sample and check outputs, then drive inputs and predict.
  task automatic step(input logic fs, input logic ls, input logic act);
    logic [15:0] w;
    logic [7:0]  g;
    logic        sw;
    @(negedge clk);
    obs_v = pix_valid; obs_c = pix_color; obs_va = vram_addr; obs_fa = font_addr;
    if (obs_v) cnt_v++;
    if (obs_va == 10'd999) seen999 = 1;
    if (track && obs_va != last_va) begin
      chk("vaddr_step", obs_va, last_va + 1);
      last_va = obs_va;
    end
    chk("pix_valid", obs_v, exp_v);
    chk("pix_color", obs_c, exp_c);
    frame_start = fs; line_start = ls; active = act;
    if (fs) begin fcnt++; L = -1; end
    if (ls) begin L++; k = 0; end
    exp_v = act && !fs && !ls && L >= 0 && L < ROWS_DEFAULT * CHAR_H && k < PIX_PER_LINE;
    exp_c = 4'd0;
    if (exp_v) begin
      w  = vram[(L / 8) * 40 + k / 8];
      g  = font[{w[7:0], 3'(L % 8)}];
      sw = CUR_EN && ((fcnt / 32) % 2 == 1) && (L / 8 == 0) && (k / 8 == 1);
      exp_c = (g[7 - (k % 8)] ^ sw) ? w[15:12] : w[11:8];
      k++;
    end
  endtask

  task automatic run_line(input int nact, input int gap_at, input bit trk);
    step(0, 1, 0);
    step(0, 0, 0);
    if (L < 200) chk("vaddr_t1", obs_va, (L / 8) * 40);
    last_va = obs_va; track = trk;
    step(0, 0, 0);
    if (L < 200) chk("faddr_t2", obs_fa, {vram[(L / 8) * 40][7:0], 3'(L % 8)});
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < nact; i++) begin
      if (i == gap_at) repeat (3) step(0, 0, 0);
      step(0, 0, 1);
    end
    repeat (2) step(0, 0, 0);
    track = 0;
  endtask

  initial begin
    vec_t tbl [4];
    tbl[0] = '{16'hE441, 8'hF0, 1'b0, 11'h208, 32'hEEEE4444};
    tbl[1] = '{16'h1230, 8'h81, 1'b0, 11'h180, 32'h12222221};
    tbl[2] = '{16'h5A7F, 8'h00, 1'b1, 11'h3F8, 32'hAAAAAAAA};
    tbl[3] = '{16'hF0FF, 8'hAA, 1'b1, 11'h7F8, 32'hF0F0F0F0};

    for (int i = 0; i < 1024; i++) vram[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);

    rst_n = 1'b0; frame_start = 0; line_start = 0; active = 0;
    repeat (2) @(negedge clk);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_font_addr", font_addr, 0);
    chk("rst_pix_color", pix_color, 0);
    chk("rst_pix_valid", pix_valid, 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    // First cell of a fresh frame, hand-computed pixel rows
    for (int t = 0; t < 4; t++) begin
      vram[0] = tbl[t].word;
      font[{tbl[t].word[7:0], 3'd0}] = tbl[t].glyph;
      if (tbl[t].same) step(1, 1, 0);
      else begin step(1, 0, 0); step(0, 1, 0); end
      step(0, 0, 0);
      chk("tbl_vaddr", obs_va, 0);
      step(0, 0, 0);
      chk("tbl_faddr", obs_fa, tbl[t].faddr);
      repeat (3) step(0, 0, 0);
      for (int p = 0; p <= 8; p++) begin
        step(0, 0, p < 8);
        if (p > 0) begin
          chk("tbl_valid", obs_v, 1);
          chk("tbl_pix", obs_c, tbl[t].pix[p - 1]);
        end
      end
    end

    // Whole frame: 201 lines, full lines at the interesting rows
    seen999 = 0;
    step(1, 0, 0);
    for (int l = 0; l < 201; l++) begin
      cnt_v = 0;
      if (l == 0)                        run_line(330, -1, 1);
      else if (l == 8)                   run_line(320, 20, 0);
      else if (l == 199 || l == 200)     run_line(320, -1, 0);
      else                               run_line(16, -1, 0);
      if (l == 0) begin
        chk("line_valid_cnt", cnt_v, 320);
        chk("vaddr_end", last_va, 39);
      end
      if (l == 199) chk("addr999_seen", seen999, 1);
      if (l == 200) chk("row25_valid_cnt", cnt_v, 0);
    end

    // frame_start at pixel 100 of a line
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    repeat (100) step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    chk("fs_mid_drop", obs_v, 0);
    repeat (5) step(0, 0, 1);
    step(0, 0, 0);
    run_line(16, -1, 0);

    // line_start while the first fetch is still in flight
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    run_line(24, -1, 0);

    // cursor blink phase: on at 32 frames, off again at 64
    while (fcnt % 64 != 32) step(1, 0, 0);
    run_line(24, -1, 0);
    while (fcnt % 64 != 0) step(1, 0, 0);
    run_line(24, -1, 0);
    step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
